// File: rtl/pedestrian_light.sv
// Purpose : pedestrian-side requester/observer for the car light controller.
//           Debounces the push-button, pulses BTN_REQ, grants walk only while cars
//           are held at red, and latches a sticky FAULT if red is lost mid-walk.
// Latency : stable BTN_RAW rise -> BTN_REQ high after DEBOUNCE_CYCLES+3 edges.
// Backpr. : none; presses arriving outside IDLE are dropped, not queued.
//
// Ports:
//   CLK      system clock
//   RESN     asynchronous active-low reset
//   BTN_RAW  raw bouncy button, asynchronous to CLK
//   RGB_CAR  car light {R,G,B}; 3'b100 is red
//   BTN_REQ  request pulse into the car controller's BTN input
//   PED_RG   pedestrian light {red,green}: 2'b10 stop, 2'b01 walk
//   WAIT_LED request registered and not yet served
//   FAULT    sticky: car light left red during walk
//
// Optional build macro PED_FLASH_EN: green blinks during the last FLASH_CYCLES
// of walk, toggling every BLINK_HALF cycles and starting with green off.
module pedestrian_light #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd20,
  parameter logic [31:0] REQ_CYCLES      = 32'd3,
  parameter logic [31:0] CLEAR_CYCLES    = 32'd10,
  parameter logic [31:0] WALK_CYCLES     = 32'd40,
  parameter logic [31:0] FLASH_CYCLES    = 32'd12,
  parameter logic [31:0] BLINK_HALF      = 32'd2
) (
  input  logic       CLK,
  input  logic       RESN,
  input  logic       BTN_RAW,
  input  logic [2:0] RGB_CAR,
  output logic       BTN_REQ,
  output logic [1:0] PED_RG,
  output logic       WAIT_LED,
  output logic       FAULT
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RED = 3'd2,
    CLEAR    = 3'd3,
    WALK     = 3'd4,
    EXIT     = 3'd5
  } state_t;

  // Blink configuration is checked in every build so a bad parameter set is
  // caught before anyone turns the flash option on.
  if (FLASH_CYCLES > WALK_CYCLES || BLINK_HALF == 32'd0) begin : g_bad_flash_cfg
    $error("pedestrian_light: need FLASH_CYCLES <= WALK_CYCLES and BLINK_HALF > 0");
  end

`ifdef PED_FLASH_EN
  // Walk cycle index at which blinking starts; when it is 0 green starts off.
  localparam logic [31:0] FLASH_START      = WALK_CYCLES - FLASH_CYCLES;
  localparam logic        WALK_START_GREEN = (FLASH_START != 32'd0);
`else
  localparam logic        WALK_START_GREEN = 1'b1;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        sync1, sync2;
  logic        deb, deb_d;
  logic [31:0] deb_cnt;
  logic [31:0] deb_cnt_inc;
  logic        press;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic        car_red;
`ifdef PED_FLASH_EN
  logic [31:0] blink_cnt;
`endif

  assign deb_cnt_inc = sat_inc(deb_cnt);
  assign cnt_inc     = sat_inc(cnt);
  assign car_red     = (RGB_CAR == 3'b100);
  // deb_d lags deb by one edge, so this is high for the single cycle after
  // the debounced level rises.
  assign press       = deb & ~deb_d;

  // Button path: 2-flop synchronizer followed by a run-length debouncer.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= BTN_RAW;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 != deb) begin
        deb_cnt <= deb_cnt_inc;
        if (deb_cnt_inc >= DEBOUNCE_CYCLES) begin
          deb <= ~deb;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Request / crossing sequencer with registered outputs.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state     <= IDLE;
      cnt       <= '0;
      BTN_REQ   <= 1'b0;
      PED_RG    <= 2'b10;
      WAIT_LED  <= 1'b0;
      FAULT     <= 1'b0;
`ifdef PED_FLASH_EN
      blink_cnt <= '0;
`endif
    end else begin
`ifdef PED_FLASH_EN
      // Preloaded so a blink window that covers the whole walk starts cleanly.
      if (state != WALK) begin
        blink_cnt <= 32'd1;
      end
`endif
      unique case (state)
        IDLE: begin
          PED_RG <= 2'b10;
          if (press) begin
            state    <= REQ;
            BTN_REQ  <= 1'b1;
            WAIT_LED <= 1'b1;
            cnt      <= '0;
          end
        end

        REQ: begin
          if (cnt_inc >= REQ_CYCLES) begin
            BTN_REQ <= 1'b0;
            state   <= WAIT_RED;
            cnt     <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // The red sample that leaves WAIT_RED is the first clearance cycle.
        WAIT_RED: begin
          if (car_red) begin
            if (CLEAR_CYCLES <= 32'd1) begin
              state    <= WALK;
              PED_RG   <= {1'b0, WALK_START_GREEN};
              WAIT_LED <= 1'b0;
              cnt      <= '0;
            end else begin
              state <= CLEAR;
              cnt   <= 32'd1;
            end
          end
        end

        CLEAR: begin
          if (!car_red) begin
            state <= WAIT_RED;
            cnt   <= '0;
          end else if (cnt_inc >= CLEAR_CYCLES) begin
            state    <= WALK;
            PED_RG   <= {1'b0, WALK_START_GREEN};
            WAIT_LED <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // cnt holds the index of the current walk cycle.
        WALK: begin
          if (!car_red) begin
            FAULT  <= 1'b1;
            PED_RG <= 2'b10;
            state  <= EXIT;
            cnt    <= '0;
          end else if (cnt_inc >= WALK_CYCLES) begin
            PED_RG <= 2'b10;
            state  <= EXIT;
            cnt    <= '0;
          end else begin
            cnt <= cnt_inc;
`ifdef PED_FLASH_EN
            if (cnt_inc == FLASH_START) begin
              PED_RG    <= 2'b00;
              blink_cnt <= 32'd1;
            end else if (cnt_inc > FLASH_START) begin
              if (blink_cnt >= BLINK_HALF) begin
                PED_RG[0] <= ~PED_RG[0];
                blink_cnt <= 32'd1;
              end else begin
                blink_cnt <= sat_inc(blink_cnt);
              end
            end
`endif
          end
        end

        // Hold until the car light leaves red so one red phase serves one request.
        EXIT: begin
          PED_RG <= 2'b10;
          if (!car_red) begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          PED_RG <= 2'b10;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pedestrian_light.sv
// Purpose : directed self-checking bench for pedestrian_light.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled there.
// Backpr. : not applicable.
module tb_pedestrian_light;

  logic       CLK     = 1'b0;
  logic       RESN    = 1'b0;
  logic       BTN_RAW = 1'b1;
  logic [2:0] RGB_CAR = 3'b010;
  logic       BTN_REQ;
  logic [1:0] PED_RG;
  logic       WAIT_LED;
  logic       FAULT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] pat;

  pedestrian_light #(
    .DEBOUNCE_CYCLES(32'd4),
    .REQ_CYCLES     (32'd3),
    .CLEAR_CYCLES   (32'd5),
    .WALK_CYCLES    (32'd10),
    .FLASH_CYCLES   (32'd4),
    .BLINK_HALF     (32'd2)
  ) dut (
    .CLK     (CLK),
    .RESN    (RESN),
    .BTN_RAW (BTN_RAW),
    .RGB_CAR (RGB_CAR),
    .BTN_REQ (BTN_REQ),
    .PED_RG  (PED_RG),
    .WAIT_LED(WAIT_LED),
    .FAULT   (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Release, let the debounced level fall, then press and hold. Request appears
  // on the 7th edge (4 debounce + 3) and lasts 3 cycles; ends in WAIT_RED.
  task automatic press_req(input string tag);
    RGB_CAR = 3'b010;
    BTN_RAW = 1'b0;
    tick(8);
    BTN_RAW = 1'b1;
    tick(6);
    chk({tag, "_req_early"}, 32'(BTN_REQ), 32'd0);
    tick(1);
    chk({tag, "_req_start"}, 32'(BTN_REQ), 32'd1);
    chk({tag, "_wait_led"},  32'(WAIT_LED), 32'd1);
    tick(2);
    chk({tag, "_req_last"},  32'(BTN_REQ), 32'd1);
    tick(1);
    chk({tag, "_req_end"},   32'(BTN_REQ), 32'd0);
  endtask

  // From WAIT_RED: red for 5 cycles -> walk for 10 cycles -> stop; then car green.
  task automatic walk_nominal(input string tag);
    RGB_CAR = 3'b100;
    tick(4);
    chk({tag, "_pre_walk"}, 32'(PED_RG), 32'd2);
    tick(1);
    chk({tag, "_walk_wait_led"}, 32'(WAIT_LED), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_green_%0d", tag, k), 32'(PED_RG[0]), 32'(pat[k]));
      chk($sformatf("%s_red_%0d", tag, k),   32'(PED_RG[1]), 32'd0);
      if (k != 9) tick(1);
    end
    tick(1);
    chk({tag, "_walk_end"}, 32'(PED_RG), 32'd2);
    tick(5);
    chk({tag, "_exit_hold"}, 32'(PED_RG), 32'd2);
    chk({tag, "_exit_req"},  32'(BTN_REQ), 32'd0);
    RGB_CAR = 3'b010;
    tick(1);
    chk({tag, "_idle"}, 32'(PED_RG), 32'd2);
  endtask

  initial begin
`ifdef PED_FLASH_EN
    pat = 10'b1100111111;
`else
    pat = 10'b1111111111;
`endif

    // Reset held with button pressed and car green.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_ped",   32'(PED_RG),   32'd2);
      chk("rst_req",   32'(BTN_REQ),  32'd0);
      chk("rst_wait",  32'(WAIT_LED), 32'd0);
      chk("rst_fault", 32'(FAULT),    32'd0);
    end
    BTN_RAW = 1'b0;
    RESN    = 1'b1;
    tick(3);
    chk("idle_ped",  32'(PED_RG),   32'd2);
    chk("idle_req",  32'(BTN_REQ),  32'd0);
    chk("idle_wait", 32'(WAIT_LED), 32'd0);

    // Nominal crossing.
    press_req("nom");
    walk_nominal("nom");
    chk("nom_fault", 32'(FAULT), 32'd0);

    // Bounce rejection: toggling every 2 cycles never builds 4 stable samples.
    BTN_RAW = 1'b0;
    tick(8);
    for (int i = 0; i < 10; i++) begin
      BTN_RAW = ~i[0];
      tick(1);
      chk("bounce_req", 32'(BTN_REQ), 32'd0);
      tick(1);
      chk("bounce_req", 32'(BTN_REQ), 32'd0);
    end
    press_req("stable");

    // Clearance restart: red 3, green 1, then red; walk after 5th consecutive red.
    RGB_CAR = 3'b100;
    tick(3);
    RGB_CAR = 3'b010;
    tick(1);
    chk("clr_break_ped", 32'(PED_RG), 32'd2);
    RGB_CAR = 3'b100;
    tick(4);
    chk("clr_4th_red", 32'(PED_RG), 32'd2);
    tick(1);
    chk("clr_5th_red", 32'(PED_RG), 32'd1);
    chk("clr_fault",   32'(FAULT),  32'd0);
    tick(9);
    chk("clr_walk_last", 32'(PED_RG), 32'd1);
    tick(1);
    chk("clr_walk_end", 32'(PED_RG), 32'd2);
    RGB_CAR = 3'b010;
    tick(1);
    chk("clr_fault_end", 32'(FAULT), 32'd0);

    // Safety fault: car turns yellow during the 4th walk cycle.
    press_req("flt");
    RGB_CAR = 3'b100;
    tick(5);
    chk("flt_walk_start", 32'(PED_RG), 32'd1);
    tick(3);
    chk("flt_walk_4", 32'(PED_RG), 32'd1);
    chk("flt_pre",    32'(FAULT),  32'd0);
    RGB_CAR = 3'b110;
    tick(1);
    chk("flt_ped",   32'(PED_RG), 32'd2);
    chk("flt_fault", 32'(FAULT),  32'd1);
    tick(3);
    chk("flt_sticky", 32'(FAULT), 32'd1);

    // Second request after the fault still completes a normal crossing.
    press_req("post");
    walk_nominal("post");
    chk("post_fault", 32'(FAULT), 32'd1);

    // Asynchronous reset mid-walk clears everything immediately.
    press_req("arst");
    RGB_CAR = 3'b100;
    tick(7);
    chk("arst_walk",  32'(PED_RG), 32'd1);
    chk("arst_fault", 32'(FAULT),  32'd1);
    #2;
    RESN = 1'b0;
    #1;
    chk("arst_ped",   32'(PED_RG),   32'd2);
    chk("arst_fclr",  32'(FAULT),    32'd0);
    chk("arst_wait",  32'(WAIT_LED), 32'd0);
    chk("arst_req",   32'(BTN_REQ),  32'd0);
    tick(1);
    BTN_RAW = 1'b0;
    RESN    = 1'b1;
    tick(2);
    chk("arst_after_ped",   32'(PED_RG), 32'd2);
    chk("arst_after_fault", 32'(FAULT),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
